// File: rtl/dma_pkg.sv
// Shared constants and enums for the DMA channel arbiter.
package dma_pkg;

    localparam int unsigned DMA_N_CHANNELS = 4;
    localparam int unsigned DMA_CHANNEL_W  = $clog2(DMA_N_CHANNELS);

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational circular first-one search starting at start_i, with per-channel exclusion.
module dma_rr_pick
    import dma_pkg::*;
#(
    parameter int unsigned N_CHANNELS = DMA_N_CHANNELS,
    parameter int unsigned CHANNEL_W  = DMA_CHANNEL_W
) (
    input  logic [N_CHANNELS-1:0] req_i,
    input  logic [CHANNEL_W-1:0]  start_i,
    input  logic [N_CHANNELS-1:0] excl_i,
    output logic [CHANNEL_W-1:0]  idx_o,
    output logic                  found_o
);

    logic [N_CHANNELS-1:0] w_masked;

    assign w_masked = req_i & ~excl_i;

    always_comb begin
        int unsigned cand;
        cand    = 0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned k = 0; k < N_CHANNELS; k++) begin
            cand = 32'(start_i) + k;
            if (cand >= N_CHANNELS) begin
                cand = cand - N_CHANNELS;
            end
            if (!found_o && w_masked[CHANNEL_W'(cand)]) begin
                found_o = 1'b1;
                idx_o   = CHANNEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter_rr.sv
// DMA channel arbiter: fixed-priority or round-robin grant of the transfer engine, with
// burst-locked ownership released on done, request withdrawal or beat-quantum expiry.
module dma_channel_arbiter_rr
    import dma_pkg::*;
#(
    parameter int unsigned N_CHANNELS = DMA_N_CHANNELS,
    parameter int unsigned QUANTUM    = 16,
    parameter int unsigned CHANNEL_W  = $clog2(N_CHANNELS),
    parameter int unsigned CNT_W      = (QUANTUM == 0) ? 1 : $clog2(QUANTUM + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_CHANNELS-1:0] req_i,
    input  logic [N_CHANNELS-1:0] ch_en_i,
    input  logic                  mode_i,
    input  logic                  beat_i,
    input  logic                  done_i,
    output logic [N_CHANNELS-1:0] grant_o,
    output logic [CHANNEL_W-1:0]  grant_idx_o,
    output logic                  grant_valid_o,
    output logic                  preempt_o
);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((QUANTUM == 0) ? 0 : QUANTUM - 1);
    localparam logic [CNT_W-1:0]      CNT_SAT  = CNT_W'(QUANTUM);
    localparam logic [CHANNEL_W-1:0]  IDX_LAST = CHANNEL_W'(N_CHANNELS - 1);
    localparam logic [N_CHANNELS-1:0] ONE      = N_CHANNELS'(1);

    arb_state_e            r_state, w_state_d;
    logic [N_CHANNELS-1:0] r_grant, w_grant_d;
    logic [CHANNEL_W-1:0]  r_idx, w_idx_d;
    logic                  r_valid, w_valid_d;
    logic                  r_preempt, w_preempt_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d;
    logic [CHANNEL_W-1:0]  r_ptr, w_ptr_d;

    logic [N_CHANNELS-1:0] w_eff;
    logic [N_CHANNELS-1:0] w_owner_onehot;
    logic [N_CHANNELS-1:0] w_excl;
    logic                  w_owner_req;
    logic                  w_quantum_hit;
    logic                  w_preempt_rel;
    logic                  w_release;
    logic                  w_others;
    logic                  w_arb;
    arb_mode_e             w_mode;
    logic [CHANNEL_W-1:0]  w_start;
    logic [CHANNEL_W-1:0]  w_pick_idx;
    logic                  w_pick_found;

    assign w_eff          = req_i & ch_en_i;
    assign w_owner_onehot = ONE << r_idx;
    assign w_owner_req    = w_eff[r_idx];
    assign w_quantum_hit  = (QUANTUM != 0) && beat_i && (r_cnt == CNT_LAST);
    assign w_release      = done_i || !w_owner_req || w_quantum_hit;
    assign w_others       = |(w_eff & ~w_owner_onehot);

    // Only a genuine quantum expiry preempts: done or a dropped request take precedence.
    assign w_preempt_rel  = (r_state == ARB_OWN) && w_quantum_hit && !done_i && w_owner_req;
    assign w_excl         = (w_preempt_rel && w_others) ? w_owner_onehot : '0;

    assign w_mode  = arb_mode_e'(mode_i);
    assign w_start = (w_mode == ARB_RR) ? ((r_ptr == IDX_LAST) ? '0 : r_ptr + CHANNEL_W'(1))
                                        : '0;

    dma_rr_pick #(
        .N_CHANNELS(N_CHANNELS),
        .CHANNEL_W (CHANNEL_W)
    ) u_pick (
        .req_i  (w_eff),
        .start_i(w_start),
        .excl_i (w_excl),
        .idx_o  (w_pick_idx),
        .found_o(w_pick_found)
    );

    always_comb begin
        w_state_d   = r_state;
        w_grant_d   = r_grant;
        w_idx_d     = r_idx;
        w_valid_d   = r_valid;
        w_preempt_d = 1'b0;
        w_cnt_d     = r_cnt;
        w_ptr_d     = r_ptr;
        w_arb       = 1'b0;

        unique case (r_state)
            ARB_IDLE: w_arb = 1'b1;
            ARB_OWN: begin
                if (w_release) begin
                    w_arb = 1'b1;
                end else if (beat_i && (r_cnt != CNT_SAT)) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
        endcase

        if (w_arb) begin
            if (w_pick_found) begin
                w_state_d   = ARB_OWN;
                w_grant_d   = ONE << w_pick_idx;
                w_idx_d     = w_pick_idx;
                w_valid_d   = 1'b1;
                w_cnt_d     = '0;
                w_preempt_d = w_preempt_rel;
                if (w_mode == ARB_RR) begin
                    w_ptr_d = w_pick_idx;
                end
            end else begin
                w_state_d = ARB_IDLE;
                w_grant_d = '0;
                w_idx_d   = '0;
                w_valid_d = 1'b0;
                w_cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_preempt <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= IDX_LAST;
        end else begin
            r_state   <= w_state_d;
            r_grant   <= w_grant_d;
            r_idx     <= w_idx_d;
            r_valid   <= w_valid_d;
            r_preempt <= w_preempt_d;
            r_cnt     <= w_cnt_d;
            r_ptr     <= w_ptr_d;
        end
    end

    assign grant_o       = r_grant;
    assign grant_idx_o   = r_idx;
    assign grant_valid_o = r_valid;
    assign preempt_o     = r_preempt;

endmodule

// File: doc/dma_channel_arbiter_rr.md
Name: dma_channel_arbiter_rr

Overview:
Parametrised DMA channel arbiter that selects one requesting channel to own the transfer engine. It supports run-time selectable fixed-priority or round-robin arbitration, per-channel enable masking, and burst-locked grants. A grant is held until the engine signals completion, the owner withdraws its request, or a beat quantum expires. It sits between the channel register blocks and the single DMA transfer engine.

Parameters:
N_CHANNELS, 4, number of requesting channels (>=2)
QUANTUM, 16, max beats per grant before forced release; 0 = unlimited (no preemption)
CHANNEL_W, $clog2(N_CHANNELS), width of channel index
CNT_W, $clog2(QUANTUM+1) (min 1), beat counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  N_CHANNELS  level request per channel
ch_en_i  in  N_CHANNELS  channel enable mask; request ignored when 0
mode_i  in  1  0 = fixed priority (ch0 highest), 1 = round-robin
beat_i  in  1  engine completed one beat for current owner
done_i  in  1  engine finished the owner's transfer
grant_o  out  N_CHANNELS  one-hot registered grant
grant_idx_o  out  CHANNEL_W  binary index of owner; valid when grant_valid_o
grant_valid_o  out  1  a channel currently owns the engine
preempt_o  out  1  one-cycle pulse when a grant ends by quantum expiry

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. On reset: grant_o=0, grant_idx_o=0, grant_valid_o=0, preempt_o=0, beat count=0, RR pointer=N_CHANNELS-1, so ch0 is searched first.
- Effective request: eff = req_i & ch_en_i.
- FSM states: IDLE and OWN.
- IDLE: if eff!=0, at next edge grant the winner: grant_o one-hot, grant_idx_o set, grant_valid_o=1, count=0, go OWN. Latency is 1 cycle from request to grant.
- OWN, release conditions evaluated each cycle:
  - (a) done_i
  - (b) eff[owner]==0
  - (c) QUANTUM!=0 and beat_i and count==QUANTUM-1
- OWN with no release: count increments on beat_i, saturating at QUANTUM.
- On release with other eff bits present: re-arbitrate in the same cycle with no bubble. The new grant is visible at the next edge, and count resets to 0.
- On release with no eff bits: next state IDLE, grant_o=0, grant_valid_o=0.
- Re-arbitration in fixed mode: the lowest-indexed eff bit wins, and the previous owner may win again.
- Re-arbitration in round-robin mode: search starts at pointer+1 mod N_CHANNELS and the first eff bit wins. The pointer is loaded with the winner index on every grant made in RR mode. It is unchanged by fixed-mode grants.
- Quantum-expiry release: the outgoing owner's request is excluded from that single arbitration when another eff bit exists, in both modes. If it is the sole requester, it is re-granted immediately. preempt_o pulses for 1 cycle at the edge the grant changes or is re-issued.
- mode_i is sampled only when arbitrating; a change mid-grant has no effect on the current owner.
- beat_i and done_i are ignored in IDLE.
- done_i and beat_i in the same cycle: release via done_i; preempt_o is not asserted.
- ch_en_i dropping for the owner releases as in (b).
- grant_o is always one-hot or zero and is consistent with grant_idx_o.
- Reset asserted mid-grant clears all state immediately (asynchronous) with no pulse on preempt_o.

Decomposition:
- dma_pkg holds N_CHANNELS, CHANNEL_W, the arbitration mode enum (ARB_FIXED=0, ARB_RR=1), and the FSM state enum (ARB_IDLE, ARB_OWN).
- One combinational sub-module, dma_rr_pick. Inputs: request vector, start index, exclusion mask. Outputs: winner index and found flag.
  - Fixed mode uses start=0 with no rotation.
  - The top level instantiates it once and owns the FSM, counter and pointer.

Test Plan:
- Fixed mode, req_i=4'b1010 held, done_i pulse after 3 cycles -> ch1 granted 1 cycle after request; after done_i, ch1 is re-granted on the next edge (still the highest priority).
- RR mode, req_i=4'b1111, done_i every 2 cycles -> grant sequence ch0, ch1, ch2, ch3, ch0 with no idle cycle between grants.
- QUANTUM=4, RR, req_i=4'b0011, beat_i continuous, no done_i -> ch0 holds for 4 beats, preempt_o pulses, then ch1 owns.
- QUANTUM=4, sole requester ch2 -> after 4 beats, preempt_o pulses and ch2 is re-granted with count reset; grant_valid_o stays 1.
- ch_en_i=4'b1110 with req_i=4'b0001 -> no grant. Owner ch1 has ch_en_i[1] cleared mid-burst -> release, then IDLE or the next winner.
- rst_ni asserted while ch3 owns in RR mode -> all outputs 0 immediately. After release with req_i=4'b1000, ch3 is granted with the pointer restarted.
